// File: rtl/txn_engine.sv
// Clocked transaction engine: validates deposit/withdraw/inquiry requests against the
// account balance and a per-day withdrawal limit, then commits and reports a status.
module txn_engine #(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned DAILY_LIMIT = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] amount_user,
    input  logic [WIDTH-1:0] amount_account,
    input  logic             day_reset,
    output logic             balance_we,
    output logic [WIDTH-1:0] new_balance,
    output logic [WIDTH-1:0] cash_user,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [2:0]       resp_status
);

    localparam logic [1:0] OP_INQ = 2'b00;
    localparam logic [1:0] OP_DEP = 2'b01;
    localparam logic [1:0] OP_WD  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [2:0] ST_OK   = 3'd0;
    localparam logic [2:0] ST_OVF  = 3'd1;
    localparam logic [2:0] ST_INS  = 3'd2;
    localparam logic [2:0] ST_LIM  = 3'd3;
    localparam logic [2:0] ST_BAD  = 3'd4;

    localparam logic [WIDTH:0] LIMIT_EXT = (WIDTH+1)'(DAILY_LIMIT);

    typedef enum logic [1:0] {StIdle, StCheck, StCommit, StResp} state_t;

    state_t           state_q, state_d;
    logic             started_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] amt_q, acct_q, total_q;
    logic [WIDTH-1:0] new_balance_q, cash_q;
    logic [2:0]       status_q;

    logic [WIDTH:0]   dep_sum, wd_sum;
    logic [2:0]       chk_status;
    logic             chk_commit;
    logic             accept;

    assign dep_sum = {1'b0, acct_q} + {1'b0, amt_q};
    assign wd_sum  = {1'b0, total_q} + {1'b0, amt_q};
    assign accept  = req_valid && req_ready;

    always_comb begin
        chk_status = ST_OK;
        if (op_q == OP_RSV || (amt_q == '0 && (op_q == OP_DEP || op_q == OP_WD))) begin
            chk_status = ST_BAD;
        end else if (op_q == OP_DEP && dep_sum[WIDTH]) begin
            chk_status = ST_OVF;
        end else if (op_q == OP_WD && amt_q > acct_q) begin
            chk_status = ST_INS;
        end else if (op_q == OP_WD && wd_sum > LIMIT_EXT) begin
            chk_status = ST_LIM;
        end
        chk_commit = (chk_status == ST_OK) && (op_q != OP_INQ);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StCheck;
            StCheck:  state_d = chk_commit ? StCommit : StResp;
            StCommit: state_d = StResp;
            StResp:   if (resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs; started_q keeps req_ready low until the first edge after reset release
    always_comb begin
        req_ready  = (state_q == StIdle) && started_q;
        balance_we = (state_q == StCommit);
        resp_valid = (state_q == StResp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= OP_INQ;
            amt_q         <= '0;
            acct_q        <= '0;
            new_balance_q <= '0;
            cash_q        <= '0;
            status_q      <= ST_OK;
        end else if (accept) begin
            op_q   <= op;
            amt_q  <= amount_user;
            acct_q <= amount_account;
        end else if (state_q == StCheck) begin
            status_q <= chk_status;
            if (chk_commit) begin
                new_balance_q <= (op_q == OP_DEP) ? dep_sum[WIDTH-1:0] : acct_q - amt_q;
                cash_q        <= amt_q;
            end else begin
                new_balance_q <= acct_q;
                cash_q        <= '0;
            end
        end
    end

    // Clear applies before the add when day_reset lands on a withdraw commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
        end else if (state_q == StCommit && op_q == OP_WD) begin
            total_q <= (day_reset ? '0 : total_q) + amt_q;
        end else if (day_reset) begin
            total_q <= '0;
        end
    end

    assign new_balance = new_balance_q;
    assign cash_user   = cash_q;
    assign resp_status = status_q;

endmodule

// File: tb/tb_txn_engine.sv
// Directed bench for txn_engine: hand-computed vectors covering each status, timing,
// daily-limit bookkeeping, response stall and mid-transaction reset.
module tb_txn_engine;

    localparam int unsigned WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] amount_user = '0;
    logic [WIDTH-1:0] amount_account = '0;
    logic             day_reset = 1'b0;
    logic             balance_we;
    logic [WIDTH-1:0] new_balance;
    logic [WIDTH-1:0] cash_user;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [2:0]       resp_status;

    int n_cmp = 0;
    int n_err = 0;

    txn_engine #(.WIDTH(WIDTH), .DAILY_LIMIT(500)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .op             (op),
        .amount_user    (amount_user),
        .amount_account (amount_account),
        .day_reset      (day_reset),
        .balance_we     (balance_we),
        .new_balance    (new_balance),
        .cash_user      (cash_user),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_status    (resp_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_day_reset();
        @(negedge clk);
        day_reset = 1'b1;
        @(posedge clk);
        #1 day_reset = 1'b0;
    endtask

    // One handshake from accept to response. ok: commit path; dr: pulse day_reset in COMMIT.
    task automatic txn(input string name, input logic [1:0] o, input int amt, input int acct,
                       input int st, input int bal, input int cash, input bit ok,
                       input bit dr, input int stall);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, ".ready"}, 32'(req_ready), 1);
        op             = o;
        amount_user    = WIDTH'(amt);
        amount_account = WIDTH'(acct);
        req_valid      = 1'b1;
        @(posedge clk);
        #1;
        req_valid      = 1'b0;
        amount_user    = WIDTH'($urandom);
        amount_account = WIDTH'($urandom);
        @(negedge clk);                                  // cycle 1: CHECK
        check({name, ".c1_we"}, 32'(balance_we), 0);
        check({name, ".c1_rv"}, 32'(resp_valid), 0);
        check({name, ".c1_rr"}, 32'(req_ready), 0);
        @(negedge clk);                                  // cycle 2
        if (ok) begin
            check({name, ".c2_we"}, 32'(balance_we), 1);
            check({name, ".c2_bal"}, 32'(new_balance), 32'(bal));
            check({name, ".c2_rv"}, 32'(resp_valid), 0);
            if (dr) day_reset = 1'b1;
            @(posedge clk);
            #1 day_reset = 1'b0;
            @(negedge clk);                              // cycle 3
        end
        check({name, ".rv"}, 32'(resp_valid), 1);
        check({name, ".we"}, 32'(balance_we), 0);
        check({name, ".st"}, 32'(resp_status), 32'(st));
        check({name, ".bal"}, 32'(new_balance), 32'(bal));
        check({name, ".cash"}, 32'(cash_user), 32'(cash));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({name, ".stall_rv"}, 32'(resp_valid), 1);
            check({name, ".stall_st"}, 32'(resp_status), 32'(st));
            check({name, ".stall_bal"}, 32'(new_balance), 32'(bal));
            check({name, ".stall_rr"}, 32'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check({name, ".done_rv"}, 32'(resp_valid), 0);
        check({name, ".done_rr"}, 32'(req_ready), 1);
    endtask

    initial begin
        #2;
        check("rst.rr", 32'(req_ready), 0);
        check("rst.rv", 32'(resp_valid), 0);
        check("rst.we", 32'(balance_we), 0);
        check("rst.bal", 32'(new_balance), 0);
        check("rst.cash", 32'(cash_user), 0);
        check("rst.st", 32'(resp_status), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel.rr", 32'(req_ready), 1);

        txn("dep100", 2'b01, 100, 900, 0, 1000, 100, 1, 0, 0);
        txn("dep124", 2'b01, 124, 900, 1, 900, 0, 0, 0, 0);
        txn("dep123", 2'b01, 123, 900, 0, 1023, 123, 1, 0, 0);
        txn("wd300", 2'b10, 300, 200, 2, 200, 0, 0, 0, 0);
        txn("wdfull", 2'b10, 200, 200, 0, 0, 200, 1, 0, 0);

        pulse_day_reset();
        txn("lim300", 2'b10, 300, 1000, 0, 700, 300, 1, 0, 0);
        txn("lim201", 2'b10, 201, 700, 3, 700, 0, 0, 0, 0);
        txn("lim200", 2'b10, 200, 700, 0, 500, 200, 1, 0, 0);
        pulse_day_reset();
        txn("lim500", 2'b10, 500, 1000, 0, 500, 500, 1, 0, 0);

        // day_reset on a commit: total becomes just that withdraw's amount (100)
        pulse_day_reset();
        txn("dr300", 2'b10, 300, 1000, 0, 700, 300, 1, 0, 0);
        txn("dr100", 2'b10, 100, 1000, 0, 900, 100, 1, 1, 0);
        txn("dr401", 2'b10, 401, 1000, 3, 1000, 0, 0, 0, 0);
        txn("dr400", 2'b10, 400, 1000, 0, 600, 400, 1, 0, 0);

        txn("rsvop", 2'b11, 5, 77, 4, 77, 0, 0, 0, 0);
        txn("dep0", 2'b01, 0, 77, 4, 77, 0, 0, 0, 0);
        txn("inq", 2'b00, 9, 42, 0, 42, 0, 0, 0, 5);

        // Reset during CHECK of a valid withdraw (daily total is 500 at this point)
        @(negedge clk);
        op             = 2'b10;
        amount_user    = WIDTH'(50);
        amount_account = WIDTH'(1000);
        req_valid      = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid.rr", 32'(req_ready), 0);
        check("mid.we", 32'(balance_we), 0);
        check("mid.rv", 32'(resp_valid), 0);
        check("mid.bal", 32'(new_balance), 0);
        check("mid.cash", 32'(cash_user), 0);
        check("mid.st", 32'(resp_status), 0);
        @(negedge clk);
        check("mid.hold_we", 32'(balance_we), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid.rel_rr", 32'(req_ready), 1);
        check("mid.rel_we", 32'(balance_we), 0);
        // Full-limit withdraw succeeds only if the daily total was cleared
        txn("post500", 2'b10, 500, 600, 0, 100, 500, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/txn_engine.md
Name: txn_engine

Overview:
Parametrised, clocked successor to the combinational amount checker in the ATM datapath. It accepts one deposit, withdraw or inquiry request per handshake and validates it against the account balance and a per-day withdrawal limit. On success it produces the new balance with a one-cycle write-enable pulse to the account store, then returns a status word to the ATM controller.

Parameters:
WIDTH, 10, bit width of amounts and balances; maximum balance is 2^WIDTH-1.
DAILY_LIMIT, 500, maximum cumulative withdrawn amount between day_reset pulses; must be at most 2^WIDTH-1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  engine can accept a request
op  in  2  00 inquiry, 01 deposit, 10 withdraw, 11 reserved
amount_user  in  WIDTH  requested amount, sampled at accept
amount_account  in  WIDTH  current balance from account store, sampled at accept
day_reset  in  1  one-cycle pulse that clears the daily withdrawn total
balance_we  out  1  one-cycle pulse; new_balance is valid to write
new_balance  out  WIDTH  balance after the transaction
cash_user  out  WIDTH  cash to dispense or accept; 0 on reject or inquiry
resp_valid  out  1  response present
resp_ready  in  1  controller takes the response
resp_status  out  3  0 OK, 1 OVERFLOW, 2 INSUFFICIENT, 3 LIMIT, 4 BAD_OP

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State returns to IDLE.
  - req_ready=0, resp_valid=0, balance_we=0.
  - new_balance=0, cash_user=0, resp_status=0.
  - Withdrawn total=0 and captured operands are cleared.
  - req_ready rises in the first cycle after rst_n deasserts.
  - Reset mid-transaction aborts it; no balance_we is issued.
- FSM states: IDLE, CHECK, COMMIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register op, amount_user and amount_account, then go to CHECK.
  - req_ready is 0 in every other state.
- CHECK (one cycle). Evaluate conditions in this priority order:
  - op==11, or amount_user==0 with op deposit/withdraw -> BAD_OP.
  - deposit with amount_account+amount_user > 2^WIDTH-1 (computed in WIDTH+1 bits; a carry-out means overflow) -> OVERFLOW.
  - withdraw with amount_user > amount_account -> INSUFFICIENT.
  - withdraw with withdrawn_total+amount_user > DAILY_LIMIT (computed in WIDTH+1 bits) -> LIMIT.
  - Otherwise the result is OK.
  - OK deposit/withdraw goes to COMMIT. OK inquiry and every reject go to RESP.
- COMMIT (one cycle):
  - balance_we=1.
  - new_balance = account+amount for deposit, account-amount for withdraw.
  - cash_user=amount_user.
  - Withdraw adds amount_user to withdrawn_total.
  - Next state is RESP.
- RESP:
  - resp_valid=1; resp_status, new_balance and cash_user are held stable.
  - Inquiry and rejects give new_balance=captured amount_account and cash_user=0.
  - When resp_valid&&resp_ready, go to IDLE and drop resp_valid next cycle. Without resp_ready the engine stalls indefinitely.
- Latency, counted from the accept edge (cycle 0):
  - CHECK in cycle 1.
  - COMMIT with balance_we in cycle 2 on the OK path.
  - resp_valid in cycle 3 on the OK path, cycle 2 on reject/inquiry.
  - Minimum back-to-back spacing is 4 cycles (OK) and 3 cycles (other).
- day_reset:
  - Clears withdrawn_total in any state.
  - If it coincides with a withdraw COMMIT, withdrawn_total becomes amount_user (clear takes effect, then the add).
  - The LIMIT check in CHECK uses the registered total, so a day_reset in that same cycle is not seen by that check.
- Boundaries:
  - Deposit landing exactly on 2^WIDTH-1 is OK.
  - Withdraw of exactly the full balance is OK; new_balance=0.
  - Withdraw landing exactly on DAILY_LIMIT is OK.
  - withdrawn_total never exceeds DAILY_LIMIT.
- Inputs amount_user and amount_account may change after accept without effect.

Test Plan:
1. WIDTH=10. Deposit 100 into 900 -> balance_we in cycle 2, new_balance=1000, cash_user=100, status 0 in cycle 3. Deposit 124 into 900 -> status 1 (OVERFLOW) in cycle 2, no balance_we, new_balance=900. Deposit 123 into 900 -> OK, new_balance=1023.
2. Withdraw 300 from 200 -> status 2 (INSUFFICIENT), cash_user=0. Withdraw 200 from 200 -> OK, new_balance=0.
3. DAILY_LIMIT=500. Withdraw 300 -> OK. Withdraw 201 -> status 3 (LIMIT). Withdraw 200 -> OK. Pulse day_reset, then withdraw 500 -> OK.
4. op=11 -> status 4. Deposit of 0 -> status 4. Inquiry on balance 42 -> status 0, new_balance=42, cash_user=0, no balance_we.
5. Hold resp_ready=0 for 5 cycles -> resp_valid and status stay stable and req_ready stays 0. Assert resp_ready -> IDLE, with req_ready=1 on the next cycle.
6. Assert rst_n=0 during CHECK of a valid withdraw -> outputs go to 0 immediately, no balance_we, withdrawn_total=0. After release, req_ready=1 within 1 cycle.
